// File: rtl/arp_rx.sv
// ARP body parser on the GMII RX clock: captures the 28-byte ARP body,
// checks the fixed fields and target IP, and reports request/reply/drop.
module arp_rx #(
    parameter int ARP_LEN   = 28,
    parameter bit CHECK_TPA = 1'b1
) (
    input  logic        mac_gmii_rx_clk,
    input  logic        mac_gmii_rx_rstn,
    input  logic [7:0]  mac_gmii_rxd,
    input  logic        mac_gmii_rx_dv,
    input  logic        mac_gmii_rx_er,
    input  logic        eth_type_arp_valid,
    input  logic [31:0] local_ip_addr,
    output logic        arp_req_valid,
    output logic        arp_rep_valid,
    output logic        arp_drop,
    output logic [47:0] arp_sha,
    output logic [31:0] arp_spa
);

    localparam int CW = $clog2(ARP_LEN + 1);

    typedef enum logic [1:0] {IDLE, BODY, TAIL} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          req_q, req_d;
    logic          rep_q, rep_d;
    logic          drop_q, drop_d;
    logic [47:0]   sha_q, sha_d;
    logic [31:0]   spa_q, spa_d;
    logic [7:0]    body_q [ARP_LEN];

    logic          start;
    logic          store;
    logic [CW-1:0] idx;
    logic [15:0]   htype, ptype, oper;
    logic [47:0]   sha;
    logic [31:0]   spa, tpa;
    logic          is_req, is_rep, fields_ok, tpa_ok;
    logic          unused_tha;

    assign start = eth_type_arp_valid && mac_gmii_rx_dv && !mac_gmii_rx_er;
    assign store = (state_q == IDLE && start) ||
                   (state_q == BODY && mac_gmii_rx_dv);
    assign idx   = (state_q == IDLE) ? '0 : cnt_q;

    assign htype = {body_q[0], body_q[1]};
    assign ptype = {body_q[2], body_q[3]};
    assign oper  = {body_q[6], body_q[7]};
    assign sha   = {body_q[8], body_q[9], body_q[10],
                    body_q[11], body_q[12], body_q[13]};
    assign spa   = {body_q[14], body_q[15], body_q[16], body_q[17]};
    assign tpa   = {body_q[24], body_q[25], body_q[26], body_q[27]};

    assign unused_tha = ^{body_q[18], body_q[19], body_q[20],
                          body_q[21], body_q[22], body_q[23]};

    assign is_req    = (oper == 16'd1);
    assign is_rep    = (oper == 16'd2);
    assign tpa_ok    = !CHECK_TPA || (tpa == local_ip_addr);
    assign fields_ok = (htype == 16'h0001) && (ptype == 16'h0800) &&
                       (body_q[4] == 8'd6) && (body_q[5] == 8'd4) &&
                       (is_req || is_rep) && tpa_ok;

    always_ff @(posedge mac_gmii_rx_clk) begin
        if (!mac_gmii_rx_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            rep_q   <= 1'b0;
            drop_q  <= 1'b0;
            sha_q   <= '0;
            spa_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            req_q   <= req_d;
            rep_q   <= rep_d;
            drop_q  <= drop_d;
            sha_q   <= sha_d;
            spa_q   <= spa_d;
        end
    end

    always_ff @(posedge mac_gmii_rx_clk) begin
        if (store) begin
            body_q[idx] <= mac_gmii_rxd;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BODY;
                    cnt_d   = CW'(1);
                    err_d   = 1'b0;
                end
            end
            BODY: begin
                if (!mac_gmii_rx_dv) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (mac_gmii_rx_er) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == CW'(ARP_LEN - 1)) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (!mac_gmii_rx_dv) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (mac_gmii_rx_er) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Verdict is registered on the edge that first samples rx_dv low.
    always_comb begin
        req_d  = 1'b0;
        rep_d  = 1'b0;
        drop_d = 1'b0;
        sha_d  = sha_q;
        spa_d  = spa_q;
        if (state_q == BODY && !mac_gmii_rx_dv) begin
            drop_d = 1'b1;
        end else if (state_q == TAIL && !mac_gmii_rx_dv) begin
            if (fields_ok && !err_q) begin
                req_d = is_req;
                rep_d = is_rep;
                sha_d = sha;
                spa_d = spa;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    assign arp_req_valid = req_q;
    assign arp_rep_valid = rep_q;
    assign arp_drop      = drop_q;
    assign arp_sha       = sha_q;
    assign arp_spa       = spa_q;

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: drives ARP bodies byte-wise and checks
// pulse counts, pulse timing and captured sender fields.
module tb_arp_rx;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rxd;
    logic        dv;
    logic        er;
    logic        arp_v;
    logic [31:0] lip;
    logic        req, rep, drop;
    logic [47:0] sha;
    logic [31:0] spa;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int req_tot = 0, rep_tot = 0, drop_tot = 0;
    int req_cyc = 0, rep_cyc = 0, drop_cyc = 0;
    int fall_cyc = 0;
    int b_req, b_rep, b_drop;

    logic [7:0] fr [64];

    localparam logic [47:0] SHA1 = 48'h020000000001;
    localparam logic [31:0] SPA1 = 32'hC0A8010A;
    localparam logic [31:0] LIP  = 32'hC0A80102;

    always #4 clk = ~clk;

    arp_rx dut (
        .mac_gmii_rx_clk    (clk),
        .mac_gmii_rx_rstn   (rstn),
        .mac_gmii_rxd       (rxd),
        .mac_gmii_rx_dv     (dv),
        .mac_gmii_rx_er     (er),
        .eth_type_arp_valid (arp_v),
        .local_ip_addr      (lip),
        .arp_req_valid      (req),
        .arp_rep_valid      (rep),
        .arp_drop           (drop),
        .arp_sha            (sha),
        .arp_spa            (spa)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req) begin
            req_tot++;
            req_cyc = cyc;
        end
        if (rep) begin
            rep_tot++;
            rep_cyc = cyc;
        end
        if (drop) begin
            drop_tot++;
            drop_cyc = cyc;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [15:0] htype,
                         input logic [15:0] oper,
                         input logic [47:0] s_mac,
                         input logic [31:0] s_ip,
                         input logic [31:0] t_ip);
        for (int i = 0; i < 64; i++) fr[i] = 8'h00;
        fr[0] = htype[15:8];
        fr[1] = htype[7:0];
        fr[2] = 8'h08;
        fr[3] = 8'h00;
        fr[4] = 8'd6;
        fr[5] = 8'd4;
        fr[6] = oper[15:8];
        fr[7] = oper[7:0];
        for (int i = 0; i < 6; i++) fr[8 + i] = s_mac[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) fr[14 + i] = s_ip[31 - 8*i -: 8];
        for (int i = 0; i < 6; i++) fr[18 + i] = 8'hFF;
        for (int i = 0; i < 4; i++) fr[24 + i] = t_ip[31 - 8*i -: 8];
    endtask

    // Drives n bytes, then exactly one dv-low cycle before returning.
    task automatic send(input int n, input int er_at,
                        input int rst_at, input bit arp);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rxd   = fr[i];
            dv    = 1'b1;
            er    = (i == er_at);
            arp_v = arp && (i == 0);
            rstn  = (i != rst_at);
        end
        @(posedge clk);
        #1;
        dv       = 1'b0;
        er       = 1'b0;
        arp_v    = 1'b0;
        rstn     = 1'b1;
        rxd      = 8'h00;
        fall_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark;
        b_req  = req_tot;
        b_rep  = rep_tot;
        b_drop = drop_tot;
    endtask

    initial begin
        rstn  = 1'b0;
        rxd   = 8'h00;
        dv    = 1'b0;
        er    = 1'b0;
        arp_v = 1'b0;
        lip   = LIP;
        idle(3);
        @(negedge clk);
        check("rst_pulses", {61'd0, req, rep, drop}, 64'd0);
        check("rst_sha", sha, 64'd0);
        check("rst_spa", spa, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        mark();
        build(16'h0001, 16'd1, SHA1, SPA1, LIP);
        send(46, -1, -1, 1'b1);
        idle(4);
        check("t1_req_cnt", req_tot - b_req, 64'd1);
        check("t1_other", (rep_tot - b_rep) + (drop_tot - b_drop), 64'd0);
        check("t1_latency", req_cyc, fall_cyc + 1);
        check("t1_sha", sha, SHA1);
        check("t1_spa", spa, SPA1);

        mark();
        build(16'h0001, 16'd2, SHA1, SPA1, LIP);
        send(46, -1, -1, 1'b1);
        idle(4);
        check("t2_rep_cnt", rep_tot - b_rep, 64'd1);
        check("t2_other", (req_tot - b_req) + (drop_tot - b_drop), 64'd0);
        check("t2_latency", rep_cyc, fall_cyc + 1);

        mark();
        build(16'h0001, 16'd1, 48'h02000000_0099, 32'hC0A80199,
              32'hC0A80103);
        send(46, -1, -1, 1'b1);
        idle(4);
        check("t3_drop_cnt", drop_tot - b_drop, 64'd1);
        check("t3_req_cnt", req_tot - b_req, 64'd0);
        check("t3_sha_kept", sha, SHA1);
        check("t3_spa_kept", spa, SPA1);

        mark();
        build(16'h0001, 16'd1, SHA1, SPA1, LIP);
        send(46, 33, -1, 1'b1);
        idle(4);
        check("t4_drop_cnt", drop_tot - b_drop, 64'd1);
        check("t4_req_cnt", req_tot - b_req, 64'd0);

        mark();
        build(16'h0001, 16'd1, 48'h0A0B0C0D0E0F, 32'h0A000001, LIP);
        send(21, -1, -1, 1'b1);
        check("t5_runt_early", drop_tot - b_drop, 64'd0);
        send(46, -1, -1, 1'b1);
        idle(4);
        check("t5_drop_cnt", drop_tot - b_drop, 64'd1);
        check("t5_drop_lat", drop_cyc, fall_cyc - 46 - 1 + 1);
        check("t5_req_cnt", req_tot - b_req, 64'd1);
        check("t5_sha", sha, 48'h0A0B0C0D0E0F);

        mark();
        build(16'h0001, 16'd1, SHA1, SPA1, LIP);
        send(46, -1, 10, 1'b1);
        idle(4);
        check("t6_rst_pulses",
              (req_tot - b_req) + (rep_tot - b_rep) + (drop_tot - b_drop),
              64'd0);
        check("t6_rst_sha", sha, 64'd0);
        check("t6_rst_spa", spa, 64'd0);

        mark();
        build(16'h0006, 16'd1, SHA1, SPA1, LIP);
        send(46, -1, -1, 1'b1);
        idle(4);
        check("t6_htype_drop", drop_tot - b_drop, 64'd1);
        check("t6_htype_req", req_tot - b_req, 64'd0);

        mark();
        build(16'h0001, 16'd1, SHA1, SPA1, LIP);
        send(46, -1, -1, 1'b0);
        idle(4);
        check("non_arp",
              (req_tot - b_req) + (rep_tot - b_rep) + (drop_tot - b_drop),
              64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
